// File: rtl/ode_mem_pkg.sv
// Shared types and defaults for the ODE solver multi-bank scratch memory.
// RD_LATENCY follows ODE_MEM_OUTREG_EN (defined: 2 cycles, undefined: 1 cycle).
package ode_mem_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } bank_state_e;

`ifdef ODE_MEM_OUTREG_EN
  localparam int unsigned RD_LATENCY = 2;
`else
  localparam int unsigned RD_LATENCY = 1;
`endif

  localparam int unsigned DEF_NUM_BANKS  = 4;
  localparam int unsigned DEF_DATA_WIDTH = 64;
  localparam int unsigned DEF_DEPTH      = 2500;
  localparam int unsigned DEF_ADDR_WIDTH = 12;

endpackage

// File: rtl/ode_mem_banks_if.sv
// Request/response/clear bus for ode_mem_banks; bank i occupies slice i of each packed field.
interface ode_mem_banks_if #(
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 12
);

  logic [NUM_BANKS-1:0]            req_valid;
  logic [NUM_BANKS-1:0]            req_ready;
  logic [NUM_BANKS-1:0]            req_we;
  logic [NUM_BANKS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_BANKS*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_BANKS-1:0]            rd_valid;
  logic [NUM_BANKS*DATA_WIDTH-1:0] rd_data;
  logic [NUM_BANKS-1:0]            addr_err;
  logic [NUM_BANKS-1:0]            clr_req;
  logic [NUM_BANKS-1:0]            clr_busy;
  logic [NUM_BANKS-1:0]            clr_done;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, clr_req,
    input  req_ready, rd_valid, rd_data, addr_err, clr_busy, clr_done
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, clr_req,
    output req_ready, rd_valid, rd_data, addr_err, clr_busy, clr_done
  );

endinterface

// File: rtl/ode_mem_bank.sv
// One 1RW scratch bank: array, IDLE/CLEAR FSM, clear counter, range check and read pipe.
// ODE_MEM_OUTREG_EN adds a second output register stage (read latency 2).
module ode_mem_bank
  import ode_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  addr_err,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done
);

  bank_state_e           state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  in_range;
  logic                  last_clr;
  logic                  s1_valid;
  logic                  s1_err;
  logic [DATA_WIDTH-1:0] s1_data;

  // A clear request in IDLE steals the cycle from any coincident request.
  always_comb begin
    req_ready = (state == ST_IDLE) && !clr_req;
    accept    = req_valid && req_ready;
    in_range  = 32'(req_addr) < DEPTH;
    last_clr  = clr_cnt == ADDR_WIDTH'(DEPTH - 1);
    clr_busy  = state == ST_CLEAR;
  end

  // Array has no reset; contents are only defined once written or cleared.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (accept && req_we && in_range) begin
      mem[req_addr] <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      clr_cnt  <= '0;
      clr_done <= 1'b0;
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_data  <= '0;
    end else begin
      clr_done <= 1'b0;
      s1_valid <= accept && !req_we;
      s1_err   <= accept && !in_range;
      if (accept && !req_we) begin
        s1_data <= in_range ? mem[req_addr] : '0;
      end
      case (state)
        ST_IDLE: begin
          if (clr_req) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end
        end
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
          if (last_clr) begin
            state    <= ST_IDLE;
            clr_done <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef ODE_MEM_OUTREG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= s1_valid;
      addr_err <= s1_err;
      rd_data  <= s1_data;
    end
  end
`else
  always_comb begin
    rd_valid = s1_valid;
    addr_err = s1_err;
    rd_data  = s1_data;
  end
`endif

endmodule

// File: rtl/ode_mem_banks.sv
// NUM_BANKS independent scratch banks for the ODE solver datapath; slices the packed bus per bank.
// Read latency is 1, or 2 when ODE_MEM_OUTREG_EN is defined.
module ode_mem_banks
  import ode_mem_pkg::*;
#(
  parameter int unsigned NUM_BANKS  = DEF_NUM_BANKS,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  ode_mem_banks_if.slave bus
);

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    ode_mem_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (bus.req_valid[i]),
      .req_ready (bus.req_ready[i]),
      .req_we    (bus.req_we[i]),
      .req_addr  (bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .req_wdata (bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH]),
      .rd_valid  (bus.rd_valid[i]),
      .rd_data   (bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .addr_err  (bus.addr_err[i]),
      .clr_req   (bus.clr_req[i]),
      .clr_busy  (bus.clr_busy[i]),
      .clr_done  (bus.clr_done[i])
    );
  end

endmodule

// File: doc/ode_mem_banks.md
# ode_mem_banks

Parametrised multi-bank, single-clock scratch memory for the ODE solver datapath, replacing the fixed four-port store with NUM_BANKS independent 1RW banks of uniform DATA_WIDTH × DEPTH. Each bank has a valid/ready request port, a registered read-data-valid strobe, address range checking and a hardware clear engine that zeroes the bank without CPU writes. It sits between the solver control FSMs (matrix A/B, state vectors, time steps) and storage.

## Interface
- NUM_BANKS, 4, number of independent banks/ports
- DATA_WIDTH, 64, word width
- DEPTH, 2500, words per bank
- ADDR_WIDTH, 12, address width; must satisfy 2^ADDR_WIDTH >= DEPTH
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  NUM_BANKS  per-bank request valid
- req_ready  out  NUM_BANKS  per-bank request ready
- req_we  in  NUM_BANKS  1 = write, 0 = read
- req_addr  in  NUM_BANKS*ADDR_WIDTH  bank i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_BANKS*DATA_WIDTH  write data, same packing
- rd_valid  out  NUM_BANKS  one-cycle strobe, read data present
- rd_data  out  NUM_BANKS*DATA_WIDTH  read data, held until next read completes
- addr_err  out  NUM_BANKS  one-cycle strobe, out-of-range access accepted
- clr_req  in  NUM_BANKS  one-cycle pulse, start zeroing bank i
- clr_busy  out  NUM_BANKS  bank i clearing
- clr_done  out  NUM_BANKS  one-cycle strobe, clear finished

## Operation
- Banks fully independent; no cross-bank arbitration or ordering.
- Per-bank FSM: IDLE, CLEAR. Reset -> IDLE.
- IDLE: req_ready = 1 unless clr_req[i] this cycle. Accept = req_valid & req_ready.
- Accepted write, addr < DEPTH: mem[addr] <= wdata; no rd_valid.
- Accepted read, addr < DEPTH: rd_data <= mem[addr], rd_valid strobes.
- Accepted access, addr >= DEPTH: write dropped; read returns rd_data = 0 with rd_valid; addr_err strobes in both cases at read-latency timing.
- IDLE & clr_req -> CLEAR, counter = 0, req_ready = 0 that same cycle (clear wins over coincident request; request not accepted, requester holds).
- CLEAR: writes 0 to mem[counter], counter++ each cycle; req_ready = 0; clr_busy = 1. After writing DEPTH-1 -> IDLE, clr_done strobes in the cycle after the last write, clr_busy falls same cycle.
- clr_req while CLEAR: ignored, no restart.
- Memory array not reset; contents undefined after power-up until written or cleared. rst_n mid-clear aborts to IDLE; partially cleared bank retains mixed contents.

## Timing
- Reset values: req_ready all 1, rd_valid 0, rd_data 0, addr_err 0, clr_busy 0, clr_done 0, counters 0.
- Read latency L = 1 cycle (accept edge N -> rd_valid high after edge N+1 ... i.e. visible cycle N+1); L = 2 with output register.
- Back-to-back reads each cycle: full throughput, one rd_valid per accepted read, in order.
- Read after write same address next cycle returns new data.
- Clear duration exactly DEPTH cycles of clr_busy; clr_done at cycle DEPTH+1 after clr_req.
- Reads in flight when clr_req arrives complete normally with pre-clear data.

## Configuration
- ODE_MEM_OUTREG_EN defined: extra output register stage on rd_data/rd_valid/addr_err, L = 2, for timing closure on large DEPTH.
- Undefined: L = 1, data registered once straight from array.

## Structure
- Package ode_mem_pkg: bank state enum (ST_IDLE, ST_CLEAR), read latency constant derived from ODE_MEM_OUTREG_EN, default DATA_WIDTH/DEPTH/ADDR_WIDTH.
- Sub-module ode_mem_bank: one bank (array, FSM, clear counter, range check, output pipe); top generates NUM_BANKS instances and slices packed buses.

## Test plan
- Bank 0 write addr 5 = 0xDEAD_BEEF_0000_0001, read addr 5 -> rd_valid[0] after L cycles, rd_data = 0xDEAD_BEEF_0000_0001, addr_err 0.
- All 4 banks write then read addr 7 with distinct data same cycle -> each bank returns own data, no cross-talk.
- Read addr 2500 on bank 1 (DEPTH 2500) -> rd_data 0, rd_valid and addr_err strobe; write addr 3000 -> addr_err, addr 2499 unchanged.
- Fill bank 2 addr 0..2499 nonzero, pulse clr_req[2] -> clr_busy 2500 cycles, req_ready low, clr_done one cycle; reads 0, 1249, 2499 return 0.
- clr_req[3] coincident with req_valid write -> write not accepted until clear done; second clr_req mid-clear ignored (busy stays exactly 2500 cycles).
- Deassert rst_n at clear cycle 100 -> all outputs at reset values immediately, FSM IDLE, req_ready 1 after release.
